// File: rtl/rr_arb4_pkg.sv
// rtl/rr_arb4_pkg.sv - state encoding and round-robin winner selection for rr_arb4_dec
package rr_arb4_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;
  localparam int   NREQ  = 4;

  // Search last+1, last+2, last+3, last (mod 4); the caller guarantees req != 0.
  function automatic logic [1:0] next_rr(input logic [NREQ-1:0] req, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dec2to4_n.sv
// rtl/dec2to4_n.sv - 2-to-4 decoder with active-low enable and active-low outputs
module dec2to4_n (
  input  logic       en_n,
  input  logic [1:0] sel,
  output logic [3:0] y_n
);

  assign y_n = en_n ? 4'b1111 : ~(4'b0001 << sel);

endmodule

// File: rtl/rr_arb4_dec.sv
// rtl/rr_arb4_dec.sv - four-way round-robin arbiter with bounded hold and decoder-style grant
module rr_arb4_dec #(
  parameter int MAX_HOLD = 8,
  parameter int HCW      = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN_L,
  input  logic [3:0] REQ,
  output logic [3:0] GNT_L,
  output logic [1:0] GIDX,
  output logic       VALID
);
  import rr_arb4_pkg::*;

  localparam logic [HCW-1:0] HOLD_TOP = HCW'(MAX_HOLD - 1);

  logic           state;
  logic           state_nxt;
  logic [1:0]     last;
  logic [1:0]     last_nxt;
  logic [1:0]     gidx_nxt;
  logic [HCW-1:0] hold;
  logic [HCW-1:0] hold_nxt;
  logic [3:0]     others;
  logic [3:0]     gnt_nxt;

  assign others = REQ & ~(4'b0001 << GIDX);

  // Every release goes through IDLE, which gives break-before-make between owners.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gidx_nxt  = GIDX;
    hold_nxt  = hold;
    if (state == IDLE) begin
      if (!EN_L && REQ != 4'b0000) begin
        state_nxt = GRANT;
        gidx_nxt  = next_rr(REQ, last);
        hold_nxt  = '0;
      end
    end else if (EN_L || !REQ[GIDX] || (hold == HOLD_TOP && others != 4'b0000)) begin
      state_nxt = IDLE;
      last_nxt  = GIDX;
    end else if (hold != HOLD_TOP) begin
      hold_nxt = hold + HCW'(1);
    end
  end

  dec2to4_n u_dec (
    .en_n (state_nxt != GRANT),
    .sel  (gidx_nxt),
    .y_n  (gnt_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      last  <= 2'd3;
      hold  <= '0;
      GIDX  <= 2'd0;
      GNT_L <= 4'b1111;
      VALID <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      hold  <= hold_nxt;
      GIDX  <= gidx_nxt;
      GNT_L <= gnt_nxt;
      VALID <= (state_nxt == GRANT);
    end
  end

endmodule

// File: tb/tb_rr_arb4_dec.sv
// tb/tb_rr_arb4_dec.sv - self-checking bench for rr_arb4_dec
module tb_rr_arb4_dec;

  localparam int MAX_HOLD = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN_L = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] GNT_L;
  logic [1:0] GIDX;
  logic       VALID;

  int errors = 0;
  int checks = 0;

  rr_arb4_dec #(.MAX_HOLD(MAX_HOLD), .HCW(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .EN_L  (EN_L),
    .REQ   (REQ),
    .GNT_L (GNT_L),
    .GIDX  (GIDX),
    .VALID (VALID)
  );

  always #5 CLK = ~CLK;

  // Reference: owner is -1 when nobody holds the resource; held counts granted cycles.
  int m_owner = -1;
  int m_last  = 3;
  int m_gidx  = 0;
  int m_held  = 0;

  task automatic model_step(input logic rst, input logic en_l, input logic [3:0] req);
    logic [3:0] rest;
    bit found;
    if (rst) begin
      m_owner = -1;
      m_last  = 3;
      m_gidx  = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      found = 0;
      if (!en_l) begin
        for (int k = 1; k <= 4; k++) begin
          if (!found && req[(m_last + k) % 4]) begin
            found   = 1;
            m_owner = (m_last + k) % 4;
            m_gidx  = m_owner;
            m_held  = 1;
          end
        end
      end
    end else begin
      rest = req;
      rest[m_owner] = 1'b0;
      if (en_l || !req[m_owner] || (m_held >= MAX_HOLD && rest != 4'b0000)) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic en_l, input logic [3:0] req);
    RESET = rst;
    EN_L  = en_l;
    REQ   = req;
    @(posedge CLK);
    #1;
    model_step(rst, en_l, req);
  endtask

  task automatic expect3(input string name, input logic [3:0] gnt, input logic [1:0] gidx, input logic valid);
    check({name, ".gnt_l"}, GNT_L, gnt);
    check({name, ".gidx"}, {2'b00, GIDX}, {2'b00, gidx});
    check({name, ".valid"}, {3'b000, VALID}, {3'b000, valid});
  endtask

  typedef struct {
    logic       rst;
    logic       en_l;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gidx;
    logic       valid;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [3:0] rreq;
    logic [3:0] mexp;
    logic       rrst;
    logic       ren;
    int         pos;
    int         slot;

    tbl[0]  = '{1'b1, 1'b0, 4'hF, 4'hF, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'hF, 4'hF, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'hF, 4'hE, 2'd0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 4'hF, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h4, 4'hB, 2'd2, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 4'h4, 4'hB, 2'd2, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 4'hF, 2'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'h4, 4'hB, 2'd2, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'hC, 4'hB, 2'd2, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'hC, 4'hF, 2'd2, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'hC, 4'hF, 2'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'hC, 4'h7, 2'd3, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'h9, 4'h7, 2'd3, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 4'h9, 4'hF, 2'd3, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'h9, 4'hF, 2'd3, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'h9, 4'hE, 2'd0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 4'h6, 4'hF, 2'd0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'h6, 4'hD, 2'd1, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 4'h6, 4'hF, 2'd0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 4'h6, 4'hD, 2'd1, 1'b1};

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].rst, tbl[i].en_l, tbl[i].req);
      expect3($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].gidx, tbl[i].valid);
    end

    // Full contention: 0,1,2,3 each for MAX_HOLD cycles separated by one blank cycle.
    cycle(1'b1, 1'b0, 4'hF);
    for (int k = 0; k < 4 * (MAX_HOLD + 1) * 2; k++) begin
      cycle(1'b0, 1'b0, 4'hF);
      pos  = k % (4 * (MAX_HOLD + 1));
      slot = pos / (MAX_HOLD + 1);
      if (pos % (MAX_HOLD + 1) < MAX_HOLD)
        expect3($sformatf("rr%0d", k), ~(4'b0001 << slot), 2'(slot), 1'b1);
      else
        expect3($sformatf("rr%0d", k), 4'hF, 2'(slot), 1'b0);
      check("rr.onehot", {3'b000, ($countones(~GNT_L) <= 1)}, 4'h1);
    end

    // Uncontended owner keeps the grant, then yields on the first contended edge.
    cycle(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b0, 4'h2);
      expect3("hold", 4'hD, 2'd1, 1'b1);
    end
    cycle(1'b0, 1'b0, 4'h3);
    expect3("preempt", 4'hF, 2'd1, 1'b0);
    cycle(1'b0, 1'b0, 4'h3);
    expect3("after_preempt", 4'hE, 2'd0, 1'b1);

    // Reset in the middle of a grant restores LAST=3.
    cycle(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 4'h4);
    expect3("mid_owner", 4'hB, 2'd2, 1'b1);
    cycle(1'b1, 1'b0, 4'h4);
    expect3("mid_reset", 4'hF, 2'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'h6);
    expect3("mid_regrant", 4'hD, 2'd1, 1'b1);

    // Random stimulus against the reference model.
    rreq = 4'hF;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rreq = 4'($urandom_range(0, 15));
      rrst = ($urandom_range(0, 99) == 0);
      ren  = ($urandom_range(0, 9) == 0);
      cycle(rrst, ren, rreq);
      mexp = (m_owner < 0) ? 4'hF : ~(4'b0001 << m_owner);
      expect3("rand", mexp, 2'(m_gidx), (m_owner >= 0));
      check("rand.valid_enc", {3'b000, VALID}, {3'b000, (GNT_L != 4'hF)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb4_dec.md
Name: rr_arb4_dec

Overview:
- Four-requester round-robin arbiter that shares one resource (bus or port) among requesters 0..3.
- The grant is presented like one half of a 2-to-4 decoder:
  - a binary index;
  - an active-low one-hot grant vector;
  - an active-low enable that blanks all grants.
- Grant hold time is bounded so that no requester can starve the others.
- Sits between the requesting blocks and the shared resource's select/enable inputs.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester keeps the grant while another request is pending (legal range 1..255).
- HCW, 8, width of the hold counter; must satisfy 2^HCW >= MAX_HOLD.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous reset, active-high.
- EN_L  in  1  active-low arbiter enable; 1 forces release and blanks all grants.
- REQ  in  4  active-high request, bit i = requester i.
- GNT_L  out  4  active-low one-hot grant; 4'b1111 = no grant.
- GIDX  out  2  binary index of current/last granted requester.
- VALID  out  1  high while a grant is active.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - All outputs are registered.
  - On RESET at a rising edge: state=IDLE, GNT_L=4'b1111, GIDX=2'd0, VALID=0, LAST=2'd3, HOLD=0.
  - RESET overrides every other input, including mid-grant.
- State IDLE (GNT_L=1111, VALID=0):
  - If EN_L=0 and REQ!=0: choose the first set REQ bit searching LAST+1, LAST+2, LAST+3, LAST (mod 4).
  - Then go to GRANT with GIDX=choice and HOLD=0.
  - Otherwise remain in IDLE.
- State GRANT (VALID=1, GNT_L=~(4'b0001<<GIDX)). Each edge, priority order:
  1. EN_L=1: go to IDLE, LAST=GIDX.
  2. REQ[GIDX]=0: release; go to IDLE, LAST=GIDX.
  3. HOLD==MAX_HOLD-1 and (REQ & ~own bit)!=0: preempt; go to IDLE, LAST=GIDX.
  4. Otherwise stay in GRANT; HOLD=HOLD+1, saturating at MAX_HOLD-1.
- Hold counter:
  - An uncontended owner keeps the grant indefinitely; HOLD stays saturated.
  - Preemption fires on the first cycle contention appears after saturation.
- Latency:
  - A REQ seen in IDLE at edge N gives the grant from edge N onward, i.e. visible in the cycle after REQ is set up.
  - Every grant change passes through at least one IDLE cycle (GNT_L=1111), giving break-before-make on the shared resource.
- GIDX holds its last value while in IDLE.
- Simultaneous events:
  - Owner release while others request: IDLE for one cycle, then round-robin from LAST+1.
  - A single requester that drops and re-raises REQ is regranted after one IDLE cycle if it is alone.
- Encoding: GNT_L never has more than one 0 bit; VALID=1 iff GNT_L!=4'b1111.

Decomposition:
- Package rr_arb4_pkg holds:
  - state encoding (IDLE=1'b0, GRANT=1'b1);
  - constant NREQ=4;
  - function next_rr(req, last) returning the 2-bit winner.
- One sub-module, dec2to4_n: combinational 2-to-4 decoder with active-low enable and active-low outputs.
  - Inputs: enable = ~grant_active, select = GIDX.
  - Its output is registered into GNT_L.

Test Plan:
- Reset: RESET=1 for 2 cycles with REQ=1111 -> GNT_L=1111, VALID=0, GIDX=0; first grant after reset goes to requester 0.
- Single requester: REQ=0100 from edge 3 -> GNT_L=1011, GIDX=2, VALID=1 after edge 3. REQ=0000 -> GNT_L=1111 after next edge.
- Full contention with MAX_HOLD=8 and REQ=1111 held:
  - Grants run 0 (8 cycles), IDLE 1, 1 (8), IDLE 1, 2, 3, back to 0.
  - Period is 36 cycles; GNT_L never has two 0 bits.
- Uncontended hold: REQ=0010 for 40 cycles -> GNT_L=1101 continuously. Then set REQ=0011 -> preempt at the next edge, IDLE, then grant 0 (GNT_L=1110).
- Enable: granted owner 3 with REQ=1001 and EN_L=1 -> GNT_L=1111 next edge, stays blank while EN_L=1. On EN_L=0 -> grant 0 (LAST=3).
- Reset mid-grant: owner 2 at HOLD=5 with RESET=1 for 1 edge -> GNT_L=1111, LAST=3. With REQ=0110 the next grant is 1.
